ex_muldiv_ctrl: RTL and testbench
=================================

EX_MULDIV_CTRL -- requirements
Module: ex_muldiv_ctrl

Interface
- REQ-001 Parameter XLEN, default 32, operand/result width.
- REQ-002 Parameter ITER, default 32, iteration cycles per multiply or divide.
- REQ-003 clk  input  1  single clock; all state updates on rising edge.
- REQ-004 rst_n  input  1  asynchronous, active-low reset.
- REQ-005 start_ex  input  1  EX stage holds an M-extension instruction.
- REQ-006 MDCode_ex  input  3  op select, funct3 order: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- REQ-007 ALU_A  input  XLEN  forwarded rs1 operand.
- REQ-008 ALU_B  input  XLEN  forwarded rs2 operand.
- REQ-009 flush_ex  input  1  kill the instruction in EX.
- REQ-010 stall_o  output  1  freezes IF/ID/EX pipeline registers.
- REQ-011 done_o  output  1  one-cycle pulse; MDResult_ex is valid.
- REQ-012 MDResult_ex  output  XLEN  multiply/divide result.

Function
- REQ-013 States: IDLE, BUSY, DONE.
- REQ-014 IDLE: start_ex=1 and flush_ex=0 latches ALU_A, ALU_B and MDCode_ex, clears the iteration counter, and goes to BUSY; stall_o=1 in that same cycle.
- REQ-015 BUSY: one radix-2 step per cycle (shift-add multiply, restoring divide on magnitudes); counter increments; the ITER-th step goes to DONE; stall_o=1 throughout.
- REQ-016 DONE: done_o=1, stall_o=0, MDResult_ex holds the sign-corrected result; next state is IDLE unconditionally, and start_ex is ignored in DONE.
- REQ-017 Latency: start at cycle 0, done_o at cycle ITER+1; back-to-back ops are accepted in the IDLE cycle after DONE.
- REQ-018 Multiply: the 2*XLEN product is formed from magnitudes and negated when the signs differ; MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits with signed/signed, signed/unsigned and unsigned/unsigned operands.
- REQ-019 Divide by zero (ALU_B=0): BUSY is skipped and DONE is entered at cycle 1; quotient=all ones; remainder=ALU_A.
- REQ-020 Signed overflow (DIV/REM, ALU_A=-2^(XLEN-1), ALU_B=-1): fast path to DONE at cycle 1; quotient=ALU_A; remainder=0.
- REQ-021 Remainder sign follows the dividend; quotient sign is the XOR of the operand signs.
- REQ-022 flush_ex in any state: next state is IDLE; stall_o drops in the same cycle (combinational); done_o is not asserted for the killed op.
- REQ-023 Operand changes on ALU_A and ALU_B after capture have no effect.
- REQ-024 MDResult_ex is 0 outside DONE.

Reset
- REQ-025 rst_n low (asynchronous, any state including BUSY): state=IDLE, counter=0, operand registers=0.
- REQ-026 Output values while rst_n is low: stall_o=0, done_o=0, MDResult_ex=0.
- REQ-027 After rst_n deasserts, the first start_ex is sampled on the first rising edge.

Configuration
- REQ-028 Macro EX_MULDIV_DIV_EN, defined: all eight ops are implemented.
- REQ-029 EX_MULDIV_DIV_EN undefined: the divide datapath is absent; DIV, DIVU, REM and REMU go IDLE->DONE in 1 cycle with MDResult_ex=0; multiply behaviour is unchanged.

Structure
- REQ-030 Package muldiv_pkg holds the MDCode_ex encodings, the state enum and the XLEN default.
- REQ-031 Sub-module md_step implements one combinational iteration step (add/shift or subtract/restore).
- REQ-032 The controller holds the FSM, counter, operand registers and sign fix-up.

Verification
- REQ-033 MUL, A=7, B=-3: stall_o high for cycles 0..32; done_o at cycle 33; MDResult_ex=0xFFFFFFEB.
- REQ-034 MULHU, A=0xFFFFFFFF, B=0xFFFFFFFF: MDResult_ex=0xFFFFFFFE at cycle 33.
- REQ-035 DIV, A=-7, B=2: MDResult_ex=0xFFFFFFFD. REM with the same operands: MDResult_ex=0xFFFFFFFF.
- REQ-036 DIVU, B=0, A=5: done_o at cycle 1, MDResult_ex=0xFFFFFFFF. DIV, A=0x80000000, B=-1: done_o at cycle 1, MDResult_ex=0x80000000.
- REQ-037 Start MUL, assert flush_ex at cycle 10: stall_o=0 in cycle 10; no done_o; the next start at cycle 12 completes at cycle 45.
- REQ-038 Start DIV, pull rst_n low at cycle 15: outputs go to 0 immediately; state=IDLE. With EX_MULDIV_DIV_EN undefined: REMU returns 0 at cycle 1.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
// Optional divide datapath: define EX_MULDIV_DIV_EN.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  // funct3 order of the M extension
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  // rs1 is treated as signed. MUL keeps unsigned magnitudes, since its low
  // half does not depend on signedness.
  function automatic logic a_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 is treated as signed
  function automatic logic b_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/md_step.sv
// One radix-2 iteration on magnitudes: shift-add multiply or restoring
// divide step. {hi, lo} is the working register pair; m is the rs2 magnitude.
// Multiply: lo holds the remaining multiplier bits, and the product builds up
// in {hi, lo}. Divide: lo holds the dividend and then the quotient, and hi
// holds the partial remainder. The divide path exists only with
// EX_MULDIV_DIV_EN.
module md_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            is_div,
  input  logic [XLEN:0]   hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] m,
  output logic [XLEN:0]   hi_n,
  output logic [XLEN-1:0] lo_n
);

  logic [XLEN:0] sum;

`ifdef EX_MULDIV_DIV_EN
  logic [XLEN:0]   sh;
  logic [XLEN+1:0] diff;
`else
  logic unused_div;
  assign unused_div = is_div;
`endif

  // Multiply step by default; the divide step overrides it when enabled.
  always_comb begin
    sum  = lo[0] ? hi + {1'b0, m} : hi;
    hi_n = {1'b0, sum[XLEN:1]};
    lo_n = {sum[0], lo[XLEN-1:1]};
`ifdef EX_MULDIV_DIV_EN
    sh   = {hi[XLEN-1:0], lo[XLEN-1]};
    diff = {1'b0, sh} - {2'b00, m};
    if (is_div) begin
      if (!diff[XLEN+1]) begin
        hi_n = diff[XLEN:0];
        lo_n = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_n = sh;
        lo_n = {lo[XLEN-2:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// EX-stage M-extension controller: FSM, iteration counter, operand capture
// and sign fix-up around the md_step datapath. The pipeline is stalled
// from the accept cycle until DONE.
// Optional divide datapath: define EX_MULDIV_DIV_EN. Without it, divide ops
// complete in one cycle with a zero result.
// The radix-2 datapath consumes one operand bit per step, so ITER must
// equal XLEN.
module ex_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_ex,
  input  logic [2:0]      MDCode_ex,
  input  logic [XLEN-1:0] ALU_A,
  input  logic [XLEN-1:0] ALU_B,
  input  logic            flush_ex,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] MDResult_ex
);

  localparam int CW = $clog2(ITER + 1);

  md_state_e         state, state_n;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_r;
  logic [XLEN-1:0]   a_r, b_r;
  logic [XLEN:0]     hi, hi_n;
  logic [XLEN-1:0]   lo, lo_n;
  logic              accept, fast_in;
  logic              neg_a_in, neg_a, neg_b;
  logic [XLEN-1:0]   mag_a_in, m;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   res;

  // Incoming operand magnitude; this loads into lo at accept.
  assign neg_a_in = a_signed(MDCode_ex) & ALU_A[XLEN-1];
  assign mag_a_in = neg_a_in ? -ALU_A : ALU_A;

  // Captured operand signs and the divisor/multiplicand magnitude.
  assign neg_a = a_signed(op_r) & a_r[XLEN-1];
  assign neg_b = b_signed(op_r) & b_r[XLEN-1];
  assign m     = neg_b ? -b_r : b_r;

`ifdef EX_MULDIV_DIV_EN
  // Divide by zero and signed overflow have fixed answers, so they skip BUSY.
  assign fast_in = MDCode_ex[2] &&
                   ((ALU_B == '0) ||
                    (((MDCode_ex == MD_DIV) || (MDCode_ex == MD_REM)) &&
                     (ALU_A == {1'b1, {(XLEN-1){1'b0}}}) && (&ALU_B)));
`else
  assign fast_in = MDCode_ex[2];
`endif

  md_step #(.XLEN(XLEN)) u_step (
    .is_div (op_r[2]),
    .hi     (hi),
    .lo     (lo),
    .m      (m),
    .hi_n   (hi_n),
    .lo_n   (lo_n)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Next state and handshake outputs. flush_ex overrides everything combinationally.
  always_comb begin
    state_n = state;
    stall_o = 1'b0;
    done_o  = 1'b0;
    accept  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_ex && !flush_ex && rst_n) begin
          accept  = 1'b1;
          stall_o = 1'b1;
          state_n = fast_in ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall_o = 1'b1;
        if (cnt == CW'(ITER - 1)) state_n = ST_DONE;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    if (flush_ex) begin
      state_n = ST_IDLE;
      stall_o = 1'b0;
      done_o  = 1'b0;
    end
  end

  // Operand capture at accept, then one datapath step per BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r <= '0;
      a_r  <= '0;
      b_r  <= '0;
      hi   <= '0;
      lo   <= '0;
      cnt  <= '0;
    end else if (accept) begin
      op_r <= MDCode_ex;
      a_r  <= ALU_A;
      b_r  <= ALU_B;
      hi   <= '0;
      lo   <= mag_a_in;
      cnt  <= '0;
    end else if ((state == ST_BUSY) && !flush_ex) begin
      hi   <= hi_n;
      lo   <= lo_n;
      cnt  <= cnt + 1'b1;
    end
  end

  // Sign fix-up and result selection. The result appears only in DONE.
  always_comb begin
    prod   = {hi[XLEN-1:0], lo};
    prod_s = (neg_a ^ neg_b) ? -prod : prod;
    res    = (op_r == MD_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    if (op_r[2]) res = div_result();
  end

  assign MDResult_ex = (state == ST_DONE) ? res : '0;

`ifdef EX_MULDIV_DIV_EN
  // Quotient sign is the XOR of the operand signs; remainder sign follows
  // the dividend.
  function automatic logic [XLEN-1:0] div_result();
    logic [XLEN-1:0] q_s, r_s;
    q_s = (neg_a ^ neg_b) ? -lo : lo;
    r_s = neg_a ? -hi[XLEN-1:0] : hi[XLEN-1:0];
    if (b_r == '0) begin
      q_s = '1;
      r_s = a_r;
    end else if (!op_r[0] && (a_r == {1'b1, {(XLEN-1){1'b0}}}) && (&b_r)) begin
      q_s = a_r;
      r_s = '0;
    end
    return op_r[1] ? r_s : q_s;
  endfunction
`else
  logic unused_a;
  assign unused_a = ^a_r;

  function automatic logic [XLEN-1:0] div_result();
    return '0;
  endfunction
`endif

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl: a vector table, directed flush and
// reset sequences, and random ops checked against a plain-arithmetic model.
// Follows EX_MULDIV_DIV_EN the same way as the RTL.
module tb_ex_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int ITER = 32;
`ifdef EX_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, start_ex = 1'b0, flush_ex = 1'b0;
  logic [2:0]  MDCode_ex = '0;
  logic [31:0] ALU_A = '0, ALU_B = '0;
  logic        stall_o, done_o;
  logic [31:0] MDResult_ex;
  int          total = 0, bad = 0;

  ex_muldiv_ctrl #(.XLEN(32), .ITER(ITER)) dut (
    .clk(clk), .rst_n(rst_n), .start_ex(start_ex), .MDCode_ex(MDCode_ex),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .flush_ex(flush_ex),
    .stall_o(stall_o), .done_o(done_o), .MDResult_ex(MDResult_ex)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, res;
    int          cyc;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference result: full-width arithmetic straight from the ISA rules
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (op < 3'd4) begin
      ea = (op == MD_MULH || op == MD_MULHSU) ? {{32{a[31]}}, a} : {32'b0, a};
      eb = (op == MD_MULH) ? {{32{b[31]}}, b} : {32'b0, b};
      p  = ea * eb;
      return (op == MD_MUL) ? p[31:0] : p[63:32];
    end
    if (!DIV_EN) return 32'h0;
    case (op)
      MD_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      MD_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MD_REM:  return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Reference latency: the cycle on which done_o appears, counted from the start cycle
  function automatic int ref_cyc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return ITER + 1;
    if (!DIV_EN || b == 0) return 1;
    if ((op == MD_DIV || op == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return ITER + 1;
  endfunction

  // Start an op on the next cycle. Keep start_ex high, as a stalled EX stage
  // would, and scramble the operands after capture.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int ecyc, output logic [31:0] res, output int cyc,
                        output bit stall_bad, output bit zero_bad);
    @(posedge clk); #1;
    start_ex = 1'b1; MDCode_ex = op; ALU_A = a; ALU_B = b;
    @(negedge clk);
    stall_bad = (stall_o !== 1'b1);
    zero_bad  = (MDResult_ex !== 32'h0) || (done_o !== 1'b0);
    cyc = -1;
    res = 'x;
    for (int c = 1; c <= 100 && cyc < 0; c++) begin
      @(posedge clk); #1;
      ALU_A = $urandom; ALU_B = $urandom;
      @(negedge clk);
      if (stall_o !== (c < ecyc)) stall_bad = 1'b1;
      if (done_o === 1'b1) begin
        cyc = c;
        res = MDResult_ex;
      end else if (MDResult_ex !== 32'h0) zero_bad = 1'b1;
    end
  endtask

  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eres, input int ecyc);
    logic [31:0] res;
    int          cyc;
    bit          sb, zb;
    run_op(op, a, b, ecyc, res, cyc, sb, zb);
    chk({name, "_res"}, res, eres);
    chk({name, "_cyc"}, cyc, ecyc);
    chk({name, "_stall"}, {31'b0, sb}, 32'h0);
    chk({name, "_zero"}, {31'b0, zb}, 32'h0);
  endtask

  initial begin
    logic [31:0] ra, rb, eres, res;
    logic [2:0]  rop;
    int          ecyc, cyc;
    bit          seen;

    tbl[0]  = '{MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, ITER + 1};
    tbl[1]  = '{MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, ITER + 1};
    tbl[2]  = '{MD_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, ITER + 1};
    tbl[3]  = '{MD_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, ITER + 1};
    tbl[4]  = '{MD_MUL,    32'h0001_0000,  32'h0001_0000, 32'h0000_0000, ITER + 1};
    tbl[5]  = '{MD_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, ITER + 1};
    tbl[6]  = '{MD_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, ITER + 1};
    tbl[7]  = '{MD_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    tbl[8]  = '{MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    tbl[9]  = '{MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1};
    tbl[10] = '{MD_REM,    32'd5,          32'd0,         32'd5,         1};
    tbl[11] = '{MD_DIVU,   32'd100,        32'd7,         32'd14,        ITER + 1};
    tbl[12] = '{MD_REMU,   32'd100,        32'd7,         32'd2,         ITER + 1};
    tbl[13] = '{MD_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         ITER + 1};
    tbl[14] = '{MD_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, ITER + 1};

    // Outputs stay quiet in reset even with a pending start
    start_ex = 1'b1; MDCode_ex = MD_MUL; ALU_A = 32'd7; ALU_B = 32'd3;
    #12;
    chk("rst_stall", {31'b0, stall_o}, 32'h0);
    chk("rst_done", {31'b0, done_o}, 32'h0);
    chk("rst_res", MDResult_ex, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; start_ex = 1'b0;

    // Vector table, back to back. Without the divider every divide op gives 0 at cycle 1.
    foreach (tbl[i]) begin
      if (tbl[i].op[2] && !DIV_EN) do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, 32'h0, 1);
      else do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].cyc);
    end

    // Flush a MUL at cycle 10, idle for cycle 11, restart at cycle 12 and finish at cycle 45
    @(posedge clk); #1;
    start_ex = 1'b1; MDCode_ex = MD_MUL; ALU_A = 32'd3; ALU_B = 32'd5;
    seen = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (done_o === 1'b1) seen = 1'b1;
    end
    @(posedge clk); #1;
    flush_ex = 1'b1;
    @(negedge clk);
    chk("flush_stall", {31'b0, stall_o}, 32'h0);
    if (done_o === 1'b1) seen = 1'b1;
    @(posedge clk); #1;
    flush_ex = 1'b0; start_ex = 1'b0;
    @(negedge clk);
    if (done_o === 1'b1 || stall_o !== 1'b0) seen = 1'b1;
    chk("flush_no_done", {31'b0, seen}, 32'h0);
    do_op("after_flush", MD_MUL, 32'd9, 32'd11, 32'd99, ITER + 1);

    // Async reset mid-operation at cycle 15
    @(posedge clk); #1;
    start_ex = 1'b1; MDCode_ex = DIV_EN ? MD_DIV : MD_MUL; ALU_A = 32'd100; ALU_B = 32'd7;
    repeat (14) @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_stall", {31'b0, stall_o}, 32'h0);
    chk("midrst_done", {31'b0, done_o}, 32'h0);
    chk("midrst_res", MDResult_ex, 32'h0);
    // Release with a start already pending, so the first rising edge accepts it
    @(negedge clk);
    MDCode_ex = MD_MUL; ALU_A = 32'd6; ALU_B = 32'd7;
    rst_n = 1'b1;
    cyc = -1;
    res = 'x;
    for (int k = 1; k <= 60 && cyc < 0; k++) begin
      @(posedge clk); #1;
      start_ex = 1'b0;
      @(negedge clk);
      if (done_o === 1'b1) begin
        cyc = k;
        res = MDResult_ex;
      end
    end
    chk("postrst_cyc", cyc, ITER + 1);
    chk("postrst_res", res, 32'd42);

    // Random ops against the model, with corner-case operands mixed in
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 20)) - 32'd10; rb = 32'($urandom_range(0, 20)) - 32'd10; end
        default: ;
      endcase
      eres = ref_res(rop, ra, rb);
      ecyc = ref_cyc(rop, ra, rb);
      do_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, eres, ecyc);
    end

    @(posedge clk); #1;
    start_ex = 1'b0;
    @(negedge clk);
    chk("end_idle_stall", {31'b0, stall_o}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
